// File: rtl/wta_knn_rank_if.sv
// Request/result bundle for the WTA/KNN ranking engine.
// The requester drives the snapshot inputs; the engine returns status and the two masks.
interface wta_knn_rank_if #(
   parameter int unsigned N_CH  = 8,
   parameter int unsigned CNT_W = 12
);
   logic                    start;
   logic [N_CH*CNT_W-1:0]   counts;
   logic [N_CH-1:0]         enable;
   logic [2:0]              k;
   logic                    busy;
   logic                    done;
   logic [N_CH-1:0]         nn;
   logic [N_CH-1:0]         knn;

   modport master (
      output start, counts, enable, k,
      input  busy, done, nn, knn
   );

   modport slave (
      input  start, counts, enable, k,
      output busy, done, nn, knn
   );
endinterface

// File: rtl/wta_knn_rank.sv
// Winner-take-all / k-nearest-neighbour ranking engine: ranks every enabled channel
// by a serial pairwise compare (one comparator, N_CH*N_CH cycles) and emits NN/KNN masks.
module wta_knn_rank #(
   parameter int unsigned N_CH       = 8,
   parameter int unsigned CNT_W      = 12,
   parameter bit          SELECT_MAX = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   wta_knn_rank_if.slave      bus
);

   localparam int unsigned IDX_W  = $clog2(N_CH);
   localparam int unsigned RANK_W = 3;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_CH - 1);
   localparam logic [RANK_W-1:0] RANK_MAX = '1;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t                        state_q, state_d;
   logic [N_CH-1:0][CNT_W-1:0]    cnt_q, cnt_d;
   logic [N_CH-1:0]               en_q, en_d;
   logic [2:0]                    k_q, k_d;
   logic [IDX_W-1:0]              i_q, i_d;
   logic [IDX_W-1:0]              j_q, j_d;
   logic [RANK_W-1:0]             rank_q, rank_d;
   logic [N_CH-1:0]               nn_sh_q, nn_sh_d;
   logic [N_CH-1:0]               knn_sh_q, knn_sh_d;
   logic                          busy_q, busy_d;
   logic                          done_q, done_d;
   logic [N_CH-1:0]               nn_q, nn_d;
   logic [N_CH-1:0]               knn_q, knn_d;

   logic [CNT_W-1:0]              cnt_i_c, cnt_j_c;
   logic                          better_c;
   logic                          beats_c;
   logic [RANK_W-1:0]             rank_inc_c;

   // Single shared comparator; equal counts resolve in favour of the lower index.
   always_comb begin
      cnt_i_c = cnt_q[i_q];
      cnt_j_c = cnt_q[j_q];
      if (SELECT_MAX)
         better_c = (cnt_j_c > cnt_i_c) || ((cnt_j_c == cnt_i_c) && (j_q < i_q));
      else
         better_c = (cnt_j_c < cnt_i_c) || ((cnt_j_c == cnt_i_c) && (j_q < i_q));
      beats_c    = en_q[j_q] && (j_q != i_q) && better_c;
      rank_inc_c = (beats_c && (rank_q != RANK_MAX)) ? RANK_W'(rank_q + 1'b1) : rank_q;
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      en_d     = en_q;
      k_d      = k_q;
      i_d      = i_q;
      j_d      = j_q;
      rank_d   = rank_q;
      nn_sh_d  = nn_sh_q;
      knn_sh_d = knn_sh_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      nn_d     = nn_q;
      knn_d    = knn_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               cnt_d   = bus.counts;
               en_d    = bus.enable;
               k_d     = bus.k;
               i_d     = '0;
               j_d     = '0;
               rank_d  = '0;
               busy_d  = 1'b1;
               state_d = SCAN;
            end
         end
         SCAN: begin
            j_d    = IDX_W'(j_q + 1'b1);
            rank_d = rank_inc_c;
            if (j_q == LAST_IDX) begin
               rank_d        = '0;
               i_d           = IDX_W'(i_q + 1'b1);
               nn_sh_d[i_q]  = en_q[i_q] & (rank_inc_c == '0);
               knn_sh_d[i_q] = en_q[i_q] & (rank_inc_c <= k_q);
               // Last pair: publish the shadows, including the entry just written.
               if (i_q == LAST_IDX) begin
                  nn_d    = nn_sh_d;
                  knn_d   = knn_sh_d;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         en_q     <= '0;
         k_q      <= '0;
         i_q      <= '0;
         j_q      <= '0;
         rank_q   <= '0;
         nn_sh_q  <= '0;
         knn_sh_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         nn_q     <= '0;
         knn_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         en_q     <= en_d;
         k_q      <= k_d;
         i_q      <= i_d;
         j_q      <= j_d;
         rank_q   <= rank_d;
         nn_sh_q  <= nn_sh_d;
         knn_sh_q <= knn_sh_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         nn_q     <= nn_d;
         knn_q    <= knn_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.nn   = nn_q;
   assign bus.knn  = knn_q;

endmodule

// File: tb/tb_wta_knn_rank.sv
// Scoreboard bench for wta_knn_rank: one instance per SELECT_MAX polarity, shared stimulus.
module tb_wta_knn_rank;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   longint cyc = 0;

   int n_cmp = 0;
   int n_mis = 0;
   int done_cnt0 = 0;
   int done_cnt1 = 0;

   typedef struct {
      logic [7:0] nn;
      logic [7:0] knn;
      longint     cyc;
      int         pop;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   wta_knn_rank_if bus0 ();
   wta_knn_rank_if bus1 ();

   wta_knn_rank #(.N_CH(8), .CNT_W(12), .SELECT_MAX(1'b0)) u_min (.clk(clk), .rst(rst), .bus(bus0));
   wta_knn_rank #(.N_CH(8), .CNT_W(12), .SELECT_MAX(1'b1)) u_max (.clk(clk), .rst(rst), .bus(bus1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [95:0] pack8(input int c0, c1, c2, c3, c4, c5, c6, c7);
      logic [95:0] p;
      p = {12'(c7), 12'(c6), 12'(c5), 12'(c4), 12'(c3), 12'(c2), 12'(c1), 12'(c0)};
      return p;
   endfunction

   // Reference: sort enabled channels by (count, index) and take the head / first k+1.
   function automatic logic [15:0] ref_rank(input logic [95:0] c, input logic [7:0] en,
                                            input logic [2:0] k, input bit smax);
      int ord[8];
      int n;
      int t;
      logic [11:0] ca, cb;
      logic [7:0] nn, knn;
      bit swap;
      n = 0;
      for (int ch = 0; ch < 8; ch++)
         if (en[ch]) begin ord[n] = ch; n++; end
      for (int a = 0; a < n; a++)
         for (int b = 0; b < n - 1 - a; b++) begin
            ca = c[ord[b]*12 +: 12];
            cb = c[ord[b+1]*12 +: 12];
            if (smax) swap = (cb > ca) || ((cb == ca) && (ord[b+1] < ord[b]));
            else      swap = (cb < ca) || ((cb == ca) && (ord[b+1] < ord[b]));
            if (swap) begin t = ord[b]; ord[b] = ord[b+1]; ord[b+1] = t; end
         end
      nn  = '0;
      knn = '0;
      if (n > 0) nn[ord[0]] = 1'b1;
      for (int p = 0; p < n; p++)
         if (p <= int'(k)) knn[ord[p]] = 1'b1;
      return {nn, knn};
   endfunction

   task automatic check_out(input int d, input logic [7:0] nn, input logic [7:0] knn, input logic busy);
      exp_t e;
      string tag;
      tag = (d == 0) ? "min" : "max";
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
         chk({tag, "_unexpected_done"}, 64'd1, 64'd0);
         return;
      end
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      chk({tag, "_nn"}, 64'(nn), 64'(e.nn));
      chk({tag, "_knn"}, 64'(knn), 64'(e.knn));
      chk({tag, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
      chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      chk({tag, "_nn_onehot"}, 64'($countones(nn) <= 1), 64'd1);
      chk({tag, "_knn_popcount"}, 64'($countones(knn)), 64'(e.pop));
   endtask

   // Monitor: sample on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus0.done) begin done_cnt0++; check_out(0, bus0.nn, bus0.knn, bus0.busy); end
         if (bus1.done) begin done_cnt1++; check_out(1, bus1.nn, bus1.knn, bus1.busy); end
      end
   end

   task automatic drive(input logic s, input logic [95:0] c, input logic [7:0] e, input logic [2:0] k);
      bus0.start = s; bus0.counts = c; bus0.enable = e; bus0.k = k;
      bus1.start = s; bus1.counts = c; bus1.enable = e; bus1.k = k;
   endtask

   task automatic push(input logic [7:0] nn0, knn0, nn1, knn1, input longint dc,
                       input logic [7:0] e, input logic [2:0] k);
      int pop;
      exp_t x;
      pop = ($countones(e) < int'(k) + 1) ? $countones(e) : int'(k) + 1;
      x.cyc = dc; x.pop = pop;
      x.nn = nn0; x.knn = knn0; q0.push_back(x);
      x.nn = nn1; x.knn = knn1; q1.push_back(x);
   endtask

   // One start pulse from IDLE; done is due 64 clocks after the accepting edge.
   task automatic issue(input logic [95:0] c, input logic [7:0] e, input logic [2:0] k,
                        input logic [7:0] nn0, knn0, nn1, knn1);
      @(negedge clk);
      drive(1'b1, c, e, k);
      @(posedge clk);
      #1;
      push(nn0, knn0, nn1, knn1, cyc + 64, e, k);
      bus0.start = 1'b0;
      bus1.start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      #1;
      if (q0.size() != 0 || q1.size() != 0) begin
         chk({name, "_timeout"}, 64'(q0.size() + q1.size()), 64'd0);
         q0.delete();
         q1.delete();
      end
   endtask

   logic [95:0] t2c;
   logic [95:0] rc;
   logic [15:0] r0, r1;
   logic [7:0]  re;
   logic [2:0]  rk;
   longint      c0;
   int          d0, d1;

   initial begin
      t2c = pack8(500, 20, 300, 20, 4095, 7, 900, 64);

      // T1: reset held with start asserted
      drive(1'b1, t2c, 8'hFF, 3'd2);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_nn", 64'(bus0.nn), 64'd0);
      chk("rst_knn", 64'(bus0.knn), 64'd0);
      chk("rst_busy", 64'(bus0.busy), 64'd0);
      chk("rst_done", 64'(bus0.done), 64'd0);
      rst = 1'b0;
      drive(1'b0, t2c, 8'hFF, 3'd2);
      repeat (3) @(negedge clk);
      chk("rst_no_scan_busy", 64'(bus0.busy | bus1.busy), 64'd0);

      // T2: basic ranking
      issue(t2c, 8'hFF, 3'd2, 8'h20, 8'h2A, 8'h10, 8'h51);
      wait_idle("t2");

      // T3: enable / threshold edges, extreme counts
      issue(t2c, 8'h00, 3'd2, 8'h00, 8'h00, 8'h00, 8'h00);
      wait_idle("t3_none");
      issue(t2c, 8'h90, 3'd7, 8'h80, 8'h90, 8'h10, 8'h90);
      wait_idle("t3_k7");
      issue(pack8(0, 0, 4095, 0, 0, 0, 0, 0), 8'hFF, 3'd0, 8'h01, 8'h01, 8'h04, 8'h04);
      wait_idle("t3_extremes");

      // T4a: start held high -> passes every 65 clocks
      @(negedge clk);
      drive(1'b1, t2c, 8'hFF, 3'd2);
      @(posedge clk);
      #1;
      c0 = cyc;
      for (int p = 0; p < 3; p++)
         push(8'h20, 8'h2A, 8'h10, 8'h51, c0 + 64 + 65 * p, 8'hFF, 3'd2);
      repeat (131) @(posedge clk);
      #1;
      bus0.start = 1'b0;
      bus1.start = 1'b0;
      wait_idle("t4_held");

      // T4b: extra starts and input changes mid-SCAN follow the snapshot
      issue(t2c, 8'h0F, 3'd0, 8'h02, 8'h02, 8'h01, 8'h01);
      repeat (10) @(negedge clk);
      drive(1'b1, '0, 8'hFF, 3'd7);
      @(negedge clk);
      drive(1'b0, '0, 8'hFF, 3'd7);
      repeat (30) @(negedge clk);
      drive(1'b1, pack8(1, 2, 3, 4, 5, 6, 7, 8), 8'hF0, 3'd1);
      @(negedge clk);
      drive(1'b0, pack8(1, 2, 3, 4, 5, 6, 7, 8), 8'hF0, 3'd1);
      wait_idle("t4_midscan");

      // T5: reset mid-scan abandons the pass
      issue(t2c, 8'hFF, 3'd2, 8'h20, 8'h2A, 8'h10, 8'h51);
      repeat (29) @(negedge clk);
      rst = 1'b1;
      q0.delete();
      q1.delete();
      @(negedge clk);
      chk("midrst_nn", 64'(bus0.nn), 64'd0);
      chk("midrst_knn", 64'(bus1.knn), 64'd0);
      chk("midrst_busy", 64'(bus0.busy | bus1.busy), 64'd0);
      rst = 1'b0;
      d0 = done_cnt0;
      d1 = done_cnt1;
      repeat (80) @(negedge clk);
      #1;
      chk("midrst_no_done", 64'((done_cnt0 - d0) + (done_cnt1 - d1)), 64'd0);
      issue(t2c, 8'hFF, 3'd2, 8'h20, 8'h2A, 8'h10, 8'h51);
      wait_idle("t5_restart");

      // T6: random passes against the sort-based reference
      for (int p = 0; p < 1000; p++) begin
         for (int ch = 0; ch < 8; ch++)
            rc[ch*12 +: 12] = (p % 3 == 0) ? 12'($urandom_range(0, 3)) : 12'($urandom_range(0, 4095));
         re = 8'($urandom);
         rk = 3'($urandom);
         r0 = ref_rank(rc, re, rk, 1'b0);
         r1 = ref_rank(rc, re, rk, 1'b1);
         issue(rc, re, rk, r0[15:8], r0[7:0], r1[15:8], r1[7:0]);
         wait_idle("t6");
      end

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
